// File: rtl/micro_sequencer.sv
// Microprogram sequencer: computes the next control-store address with dispatch,
// conditional branch, call/return stack, stall and halt/restart handling.
`timescale 1ns/1ps
module micro_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic [ADDR_W-1:0] IR,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              JMPC,
    input  logic              JCOND,
    input  logic              Z,
    input  logic              CALL,
    input  logic              RET,
    input  logic              HALT_OP,
    input  logic              STALL,
    output logic [ADDR_W-1:0] MPC,
    output logic [1:0]        STATE,
    output logic [2:0]        DEPTH,
    output logic              ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_WAIT = 2'b10,
        S_HALT = 2'b11
    } state_e;

    localparam int         PTR_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mpc_q, mpc_d;
    logic [2:0]        depth_q, depth_d;
    logic              err_q, err_d;
    logic              push_en;

    logic [ADDR_W-1:0] stack_q [2**PTR_W];

    logic [ADDR_W-1:0] mpc_plus1;
    logic [PTR_W-1:0]  push_idx;
    logic [PTR_W-1:0]  pop_idx;
    logic              run_go;
    logic              stop_err;

    assign mpc_plus1 = mpc_q + ADDR_W'(1);
    assign push_idx  = depth_q[PTR_W-1:0];
    assign pop_idx   = push_idx - PTR_W'(1);
    assign run_go    = (state_q == S_RUN) && !STALL;

    // Any of these ends the program with ERR: both stack ops at once, or a stack op past its limit.
    assign stop_err  = (CALL && RET)
                     || (RET  && (depth_q == 3'd0))
                     || (CALL && (depth_q == DEPTH_MAX));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            mpc_q   <= RESET_ADDR;
            depth_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mpc_q   <= mpc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack entries carry no reset; DEPTH alone says which ones are valid.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_q[push_idx] <= mpc_plus1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (START) state_d = S_RUN;
            S_RUN: begin
                if (STALL) begin
                    state_d = S_WAIT;
                end else if (HALT_OP || stop_err) begin
                    state_d = S_HALT;
                end
            end
            S_WAIT: if (!STALL) state_d = S_RUN;
            S_HALT: if (START) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mpc_d   = mpc_q;
        depth_d = depth_q;
        err_d   = err_q;
        push_en = 1'b0;
        if ((state_q == S_HALT) && START) begin
            mpc_d   = RESET_ADDR;
            depth_d = 3'd0;
            err_d   = 1'b0;
        end else if (run_go) begin
            if (HALT_OP) begin
                mpc_d = mpc_q;
            end else if (stop_err) begin
                err_d = 1'b1;
            end else if (RET) begin
                mpc_d   = stack_q[pop_idx];
                depth_d = depth_q - 3'd1;
            end else if (CALL) begin
                push_en = 1'b1;
                mpc_d   = ADDR;
                depth_d = depth_q + 3'd1;
            end else if (JMPC) begin
                mpc_d = IR;
            end else if (JCOND && !Z) begin
                mpc_d = mpc_plus1;
            end else begin
                mpc_d = ADDR;
            end
        end
    end

    assign MPC   = mpc_q;
    assign STATE = state_q;
    assign DEPTH = depth_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Table-driven, scoreboard-checked bench for micro_sequencer (ADDR_W=8, STACK_DEPTH=4).
`timescale 1ns/1ps
module tb_micro_sequencer;

    localparam logic [7:0] K_NONE  = 8'h00;
    localparam logic [7:0] K_START = 8'h01;
    localparam logic [7:0] K_JMPC  = 8'h02;
    localparam logic [7:0] K_JCOND = 8'h04;
    localparam logic [7:0] K_Z     = 8'h08;
    localparam logic [7:0] K_CALL  = 8'h10;
    localparam logic [7:0] K_RET   = 8'h20;
    localparam logic [7:0] K_HALT  = 8'h40;
    localparam logic [7:0] K_STALL = 8'h80;

    typedef struct {
        string      name;
        logic [7:0] ctrl;
        logic [7:0] ir;
        logic [7:0] addr;
        logic [7:0] exp_mpc;
        logic [1:0] exp_state;
        logic [2:0] exp_depth;
        logic       exp_err;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b1;
    logic       START = 1'b0;
    logic [7:0] IR = 8'h00;
    logic [7:0] ADDR = 8'h00;
    logic       JMPC = 1'b0;
    logic       JCOND = 1'b0;
    logic       Z = 1'b0;
    logic       CALL = 1'b0;
    logic       RET = 1'b0;
    logic       HALT_OP = 1'b0;
    logic       STALL = 1'b0;
    logic [7:0] MPC;
    logic [1:0] STATE;
    logic [2:0] DEPTH;
    logic       ERR;

    int n_compared = 0;
    int n_mismatched = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    micro_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .IR(IR), .ADDR(ADDR),
        .JMPC(JMPC), .JCOND(JCOND), .Z(Z), .CALL(CALL), .RET(RET),
        .HALT_OP(HALT_OP), .STALL(STALL),
        .MPC(MPC), .STATE(STATE), .DEPTH(DEPTH), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string n, logic [7:0] c, logic [7:0] ir, logic [7:0] addr,
                                logic [7:0] mpc, logic [1:0] st, logic [2:0] dep, logic err);
        vec_t v;
        v.name = n; v.ctrl = c; v.ir = ir; v.addr = addr;
        v.exp_mpc = mpc; v.exp_state = st; v.exp_depth = dep; v.exp_err = err;
        return v;
    endfunction

    task automatic checkField(string n, string f, logic [7:0] act, logic [7:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", n, f, act, exp);
        end
    endtask

    task automatic checkAll(string n, logic [7:0] mpc, logic [1:0] st, logic [2:0] dep, logic err);
        checkField(n, "MPC", MPC, mpc);
        checkField(n, "STATE", {6'd0, STATE}, {6'd0, st});
        checkField(n, "DEPTH", {5'd0, DEPTH}, {5'd0, dep});
        checkField(n, "ERR", {7'd0, ERR}, {7'd0, err});
    endtask

    task automatic driveInputs(logic [7:0] c, logic [7:0] ir, logic [7:0] addr);
        START   = c[0];
        JMPC    = c[1];
        JCOND   = c[2];
        Z       = c[3];
        CALL    = c[4];
        RET     = c[5];
        HALT_OP = c[6];
        STALL   = c[7];
        IR      = ir;
        ADDR    = addr;
    endtask

    // Drive one vector away from the active edge and record what the next edge must produce.
    task automatic applyStimulus(vec_t v);
        @(negedge CLK);
        driveInputs(v.ctrl, v.ir, v.addr);
        exp_q.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
        end else begin
            e = exp_q.pop_front();
            checkAll(e.name, e.exp_mpc, e.exp_state, e.exp_depth, e.exp_err);
        end
    endtask

    task automatic runVec(vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        tbl.push_back(mk("idle_ignore",   K_JMPC,                 8'h55, 8'h10, 8'h00, 2'b00, 3'd0, 1'b0));
        tbl.push_back(mk("start",         K_START,                8'h00, 8'h10, 8'h00, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("first_addr",    K_NONE,                 8'h00, 8'h10, 8'h10, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("jmpc",          K_JMPC,                 8'h5A, 8'h33, 8'h5A, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("goto_20",       K_NONE,                 8'h00, 8'h20, 8'h20, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("jcond_nz",      K_JCOND,                8'h00, 8'h40, 8'h21, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("jcond_z",       K_JCOND | K_Z,          8'h00, 8'h40, 8'h40, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("goto_30",       K_NONE,                 8'h00, 8'h30, 8'h30, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("call_80",       K_CALL,                 8'h00, 8'h80, 8'h80, 2'b01, 3'd1, 1'b0));
        tbl.push_back(mk("ret_31",        K_RET,                  8'h00, 8'h00, 8'h31, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("jmpc_over_jc",  K_JMPC | K_JCOND | K_Z, 8'h66, 8'h44, 8'h66, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("call_over_jmp", K_CALL | K_JMPC,        8'h99, 8'h90, 8'h90, 2'b01, 3'd1, 1'b0));
        tbl.push_back(mk("call_a0",       K_CALL,                 8'h00, 8'hA0, 8'hA0, 2'b01, 3'd2, 1'b0));
        tbl.push_back(mk("ret_91",        K_RET,                  8'h00, 8'h00, 8'h91, 2'b01, 3'd1, 1'b0));
        tbl.push_back(mk("ret_over_jmp",  K_RET | K_JMPC,         8'h12, 8'h00, 8'h67, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("goto_ff",       K_NONE,                 8'h00, 8'hFF, 8'hFF, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("wrap",          K_JCOND,                8'h00, 8'h40, 8'h00, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("stall_1",       K_STALL | K_JMPC,       8'h77, 8'h00, 8'h00, 2'b10, 3'd0, 1'b0));
        tbl.push_back(mk("stall_2",       K_STALL | K_JMPC,       8'h77, 8'h00, 8'h00, 2'b10, 3'd0, 1'b0));
        tbl.push_back(mk("stall_3",       K_STALL | K_JMPC | K_CALL, 8'h77, 8'h50, 8'h00, 2'b10, 3'd0, 1'b0));
        tbl.push_back(mk("unstall",       K_JMPC,                 8'h77, 8'h00, 8'h00, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("held_exec",     K_JMPC,                 8'h77, 8'h00, 8'h77, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("halt_op",       K_HALT | K_CALL | K_JMPC, 8'h01, 8'h02, 8'h77, 2'b11, 3'd0, 1'b0));
        tbl.push_back(mk("halt_ignore",   K_JMPC,                 8'h33, 8'h00, 8'h77, 2'b11, 3'd0, 1'b0));
        tbl.push_back(mk("restart",       K_START,                8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 1'b0));
        tbl.push_back(mk("start_2",       K_START,                8'h00, 8'h08, 8'h00, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("underflow",     K_RET,                  8'h00, 8'h00, 8'h00, 2'b11, 3'd0, 1'b1));
        tbl.push_back(mk("restart_clr",   K_START,                8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 1'b0));
        tbl.push_back(mk("start_3",       K_START,                8'h00, 8'h00, 8'h00, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("ovf_call_1",    K_CALL,                 8'h00, 8'h10, 8'h10, 2'b01, 3'd1, 1'b0));
        tbl.push_back(mk("ovf_call_2",    K_CALL,                 8'h00, 8'h20, 8'h20, 2'b01, 3'd2, 1'b0));
        tbl.push_back(mk("ovf_call_3",    K_CALL,                 8'h00, 8'h30, 8'h30, 2'b01, 3'd3, 1'b0));
        tbl.push_back(mk("ovf_call_4",    K_CALL,                 8'h00, 8'h40, 8'h40, 2'b01, 3'd4, 1'b0));
        tbl.push_back(mk("ovf_call_5",    K_CALL,                 8'h00, 8'h50, 8'h40, 2'b11, 3'd4, 1'b1));
        tbl.push_back(mk("restart_ovf",   K_START,                8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 1'b0));
        tbl.push_back(mk("start_4",       K_START,                8'h00, 8'h00, 8'h00, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("call_22",       K_CALL,                 8'h00, 8'h22, 8'h22, 2'b01, 3'd1, 1'b0));
        tbl.push_back(mk("call_and_ret",  K_CALL | K_RET,         8'h00, 8'h55, 8'h22, 2'b11, 3'd1, 1'b1));
        tbl.push_back(mk("restart_ill",   K_START,                8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 1'b0));
        tbl.push_back(mk("start_5",       K_START,                8'h00, 8'h00, 8'h00, 2'b01, 3'd0, 1'b0));
        tbl.push_back(mk("lifo_call_1",   K_CALL,                 8'h00, 8'h10, 8'h10, 2'b01, 3'd1, 1'b0));
        tbl.push_back(mk("lifo_call_2",   K_CALL,                 8'h00, 8'h20, 8'h20, 2'b01, 3'd2, 1'b0));
        tbl.push_back(mk("lifo_call_3",   K_CALL,                 8'h00, 8'h30, 8'h30, 2'b01, 3'd3, 1'b0));
        tbl.push_back(mk("lifo_call_4",   K_CALL,                 8'h00, 8'h40, 8'h40, 2'b01, 3'd4, 1'b0));
        tbl.push_back(mk("lifo_ret_1",    K_RET,                  8'h00, 8'h00, 8'h31, 2'b01, 3'd3, 1'b0));
        tbl.push_back(mk("lifo_ret_2",    K_RET,                  8'h00, 8'h00, 8'h21, 2'b01, 3'd2, 1'b0));
        tbl.push_back(mk("lifo_ret_3",    K_RET,                  8'h00, 8'h00, 8'h11, 2'b01, 3'd1, 1'b0));
        tbl.push_back(mk("lifo_ret_4",    K_RET,                  8'h00, 8'h00, 8'h01, 2'b01, 3'd0, 1'b0));

        $display("[TB] async reset check");
        #2 RSTN = 1'b0;
        #1 checkAll("reset", 8'h00, 2'b00, 3'd0, 1'b0);
        @(negedge CLK);
        RSTN = 1'b1;

        $display("[TB] running %0d table vectors", tbl.size());
        foreach (tbl[i]) begin
            runVec(tbl[i]);
        end

        // Reset landing mid-stall with a live stack entry must drop the stack.
        $display("[TB] reset during WAIT with stack occupied");
        runVec(mk("pre_call",  K_CALL,  8'h00, 8'h60, 8'h60, 2'b01, 3'd1, 1'b0));
        runVec(mk("pre_stall", K_STALL, 8'h00, 8'h00, 8'h60, 2'b10, 3'd1, 1'b0));
        @(negedge CLK);
        #1 RSTN = 1'b0;
        #1 checkAll("async_rst_wait", 8'h00, 2'b00, 3'd0, 1'b0);
        @(negedge CLK);
        driveInputs(K_NONE, 8'h00, 8'h00);
        RSTN = 1'b1;
        runVec(mk("post_rst_idle",  K_JMPC | K_CALL, 8'h44, 8'h45, 8'h00, 2'b00, 3'd0, 1'b0));
        runVec(mk("post_rst_idle2", K_NONE,          8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 1'b0));
        runVec(mk("post_rst_start", K_START,         8'h00, 8'h00, 8'h00, 2'b01, 3'd0, 1'b0));
        runVec(mk("stack_dropped",  K_RET,           8'h00, 8'h00, 8'h00, 2'b11, 3'd0, 1'b1));

        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the width of the microprogram counter, IR, ADDR and stack entries.
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the number of return-address stack entries (legal range 1..7).
REQ-003 Parameter RESET_ADDR, default 0, SHALL set the MPC value loaded on reset and on restart.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-005 Port CLK, input, 1, SHALL be the rising-edge clock for all state.
REQ-006 Port RSTN, input, 1, SHALL be the asynchronous active-low reset.
REQ-007 Port START, input, 1, SHALL be the run request in IDLE and the restart request in HALT.
REQ-008 Port IR, input, ADDR_W, SHALL be the opcode, used as the dispatch target.
REQ-009 Port ADDR, input, ADDR_W, SHALL be the next-address field of the current microinstruction.
REQ-010 Port JMPC, input, 1, SHALL request dispatch (MPC <= IR).
REQ-011 Port JCOND, input, 1, SHALL request a branch to ADDR when Z=1.
REQ-012 Port Z, input, 1, SHALL be the datapath zero flag.
REQ-013 Port CALL, input, 1, SHALL request a microsubroutine call.
REQ-014 Port RET, input, 1, SHALL request a microsubroutine return.
REQ-015 Port HALT_OP, input, 1, SHALL request a stop.
REQ-016 Port STALL, input, 1, SHALL be the memory or datapath wait request.
REQ-017 Port MPC, output, ADDR_W, SHALL be the registered control-store address.
REQ-018 Port STATE, output, 2, SHALL show the state encoding: IDLE=00, RUN=01, WAIT=10, HALT=11.
REQ-019 Port DEPTH, output, 3, SHALL show the current stack occupancy.
REQ-020 Port ERR, output, 1, SHALL be a sticky flag for stack overflow, stack underflow or an illegal CALL+RET combination.

Function
REQ-021 IDLE: MPC SHALL hold; START=1 SHALL move the block to RUN on the next edge with MPC unchanged, so the microinstruction at RESET_ADDR executes first.
REQ-022 RUN with STALL=0: MPC SHALL update every cycle by the first match in this priority order:
  - HALT_OP: hold MPC, go to HALT.
  - CALL&RET: illegal; set ERR, go to HALT.
  - RET: pop the stack to MPC.
  - CALL: push MPC+1, MPC <= ADDR.
  - JMPC: MPC <= IR.
  - JCOND&Z: MPC <= ADDR.
  - JCOND&~Z: MPC <= MPC+1.
  - Otherwise: MPC <= ADDR.
REQ-023 MPC+1 SHALL wrap modulo 2^ADDR_W (0xFF+1 = 0x00 at ADDR_W=8).
REQ-024 RUN with STALL=1: the block SHALL enter WAIT with MPC, stack and DEPTH frozen and all control inputs ignored.
REQ-025 WAIT: the block SHALL stay in WAIT while STALL=1; STALL=0 SHALL return it to RUN with MPC unchanged, and the held microinstruction SHALL then be evaluated per REQ-022.
REQ-026 CALL with DEPTH=STACK_DEPTH: no push SHALL occur, MPC SHALL hold, ERR SHALL be set to 1, and the block SHALL go to HALT.
REQ-027 RET with DEPTH=0: MPC SHALL hold, ERR SHALL be set to 1, and the block SHALL go to HALT.
REQ-028 The stack SHALL be LIFO; DEPTH SHALL increment on a push and decrement on a pop, and SHALL never exceed STACK_DEPTH.
REQ-029 HALT: MPC SHALL hold; START=1 SHALL load RESET_ADDR into MPC, clear DEPTH and ERR, and go to IDLE.
REQ-030 Control inputs SHALL be ignored in IDLE, WAIT and HALT, except START in IDLE and HALT and STALL in WAIT.
REQ-031 All outputs SHALL be registered or decoded directly from registers; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-032 RSTN=0 SHALL immediately force MPC=RESET_ADDR, STATE=IDLE, DEPTH=0 and ERR=0, regardless of CLK.
REQ-033 Reset asserted mid-operation (any state, including mid-stall or mid-call) SHALL discard the stack contents; after release the block SHALL wait in IDLE for START.
REQ-034 Stack entry contents SHALL NOT need a reset value; DEPTH alone SHALL define validity.

Verification
REQ-035 Scenario, reset and start: reset, then START=1 for one cycle with ADDR=0x10 held -> STATE 00->01; MPC=0x00 for one cycle, then 0x10.
REQ-036 Scenario, dispatch and branch:
  - JMPC=1, IR=0x5A -> MPC=0x5A next cycle.
  - JCOND=1, Z=0, MPC=0x20 -> MPC=0x21.
  - JCOND=1, Z=1, ADDR=0x40 -> MPC=0x40.
REQ-037 Scenario, call and return: at MPC=0x30, CALL=1, ADDR=0x80 -> MPC=0x80, DEPTH=1; then RET=1 -> MPC=0x31, DEPTH=0.
REQ-038 Scenario, stack limits:
  - Five nested CALLs at STACK_DEPTH=4 -> 5th call gives ERR=1, STATE=11, DEPTH=4, MPC held.
  - RET at DEPTH=0 -> ERR=1, STATE=11.
REQ-039 Scenario, stall: STALL=1 for 3 cycles with JMPC=1, IR=0x77 -> STATE=10, MPC frozen for all 3 cycles; one cycle after STALL falls, MPC=0x77.
REQ-040 Scenario, wrap, restart and reset:
  - JCOND=1, Z=0 at MPC=0xFF -> MPC=0x00.
  - START in HALT -> MPC=RESET_ADDR, ERR=0, STATE=00.
  - RSTN pulse during WAIT -> STATE=00 asynchronously.
